// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared types and constants for the cv32e40p redundancy voters
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    REQ     = 2'd1,
    SETTLE  = 2'd2
  } voter_scrub_state_e;

  localparam int unsigned VOTER_THRESH_DEFAULT = 4;

  // Index width that stays legal for single-entry arrays.
  function automatic int unsigned voter_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cv32e40p_voter_majority_2d.sv
// rtl/cv32e40p_voter_majority_2d.sv - bitwise 2-of-3 majority over a replicated 2-D array
// Purely combinational; also reports which replica disagrees with the vote per entry.
module cv32e40p_voter_majority_2d #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned N_ENTRIES = 16
) (
  input  logic [N_ENTRIES-1:0][WIDTH-1:0] res1_i,
  input  logic [N_ENTRIES-1:0][WIDTH-1:0] res2_i,
  input  logic [N_ENTRIES-1:0][WIDTH-1:0] res3_i,
  output logic [N_ENTRIES-1:0][WIDTH-1:0] result_o,
  output logic [2:0][N_ENTRIES-1:0]       dis_o
);

  for (genvar e = 0; e < N_ENTRIES; e++) begin : g_entry
    logic [WIDTH-1:0] maj;

    assign maj = (res1_i[e] & res2_i[e]) | (res1_i[e] & res3_i[e]) | (res2_i[e] & res3_i[e]);
    assign result_o[e] = maj;
    assign dis_o[0][e] = |(res1_i[e] ^ maj);
    assign dis_o[1][e] = |(res2_i[e] ^ maj);
    assign dis_o[2][e] = |(res3_i[e] ^ maj);
  end

endmodule

// File: rtl/cv32e40p_voter_scrub_2d.sv
// rtl/cv32e40p_voter_scrub_2d.sv - TMR voter with fault history and scrub requests
// Scrub FSM and payload registers only exist when CV32E40P_VOTER_SCRUB_EN is defined.
module cv32e40p_voter_scrub_2d
  import cv32e40p_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned N_ENTRIES = 16,
  parameter int unsigned THRESH    = VOTER_THRESH_DEFAULT,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned EW       = voter_idx_w(N_ENTRIES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_ENTRIES-1:0][WIDTH-1:0] res1_i,
  input  logic [N_ENTRIES-1:0][WIDTH-1:0] res2_i,
  input  logic [N_ENTRIES-1:0][WIDTH-1:0] res3_i,
  output logic [N_ENTRIES-1:0][WIDTH-1:0] result_o,
  output logic [N_ENTRIES-1:0]            mismatch_o,
  output logic [CNT_W-1:0]                err_cnt_o,
  output logic [2:0]                      faulty_o,
  output logic                            unrecov_o,
  input  logic                            clear_i,
  output logic                            scrub_req_o,
  output logic [1:0]                      scrub_repl_o,
  output logic [EW-1:0]                   scrub_entry_o,
  output logic [WIDTH-1:0]                scrub_data_o,
  input  logic                            scrub_ack_i
);

  localparam int unsigned CONS_W = $clog2(THRESH + 1);
  localparam logic [CONS_W-1:0] THRESH_C = CONS_W'(THRESH);

  logic [2:0][N_ENTRIES-1:0] dis;
  logic [2:0]                dis_any;

  logic [2:0][CONS_W-1:0] cons_q, cons_d;
  logic [2:0]             faulty_q, faulty_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;

  cv32e40p_voter_majority_2d #(
    .WIDTH     (WIDTH),
    .N_ENTRIES (N_ENTRIES)
  ) u_majority (
    .res1_i   (res1_i),
    .res2_i   (res2_i),
    .res3_i   (res3_i),
    .result_o (result_o),
    .dis_o    (dis)
  );

  assign dis_any[0] = |dis[0];
  assign dis_any[1] = |dis[1];
  assign dis_any[2] = |dis[2];
  assign mismatch_o = dis[0] | dis[1] | dis[2];

  always_comb begin
    err_cnt_d = err_cnt_q;
    cons_d    = cons_q;
    faulty_d  = faulty_q;
    if (clear_i) begin
      err_cnt_d = '0;
      cons_d    = '0;
      faulty_d  = '0;
    end else begin
      if ((|mismatch_o) && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      for (int r = 0; r < 3; r++) begin
        if (!dis_any[r]) begin
          cons_d[r] = '0;
        end else if (cons_q[r] != THRESH_C) begin
          cons_d[r] = cons_q[r] + CONS_W'(1);
        end
        // Sticky: once the run length reaches THRESH the replica stays faulty.
        if (cons_d[r] == THRESH_C) begin
          faulty_d[r] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      cons_q    <= '0;
      faulty_q  <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      cons_q    <= cons_d;
      faulty_q  <= faulty_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
  assign faulty_o  = faulty_q;
  assign unrecov_o = (faulty_q[0] & faulty_q[1]) | (faulty_q[0] & faulty_q[2]) |
                     (faulty_q[1] & faulty_q[2]);

`ifdef CV32E40P_VOTER_SCRUB_EN
  voter_scrub_state_e state_q, state_d;
  logic [1:0]         repl_q, repl_d;
  logic [EW-1:0]      entry_q, entry_d;
  logic [WIDTH-1:0]   data_q, data_d;

  logic               sel_found;
  logic [1:0]         sel_repl;
  logic [EW-1:0]      sel_entry;

  // Lowest replica first, then lowest entry within that replica.
  always_comb begin
    sel_found = 1'b0;
    sel_repl  = '0;
    sel_entry = '0;
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < int'(N_ENTRIES); e++) begin
        if (!sel_found && dis[r][e]) begin
          sel_found = 1'b1;
          sel_repl  = 2'(r);
          sel_entry = EW'(e);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    repl_d  = repl_q;
    entry_d = entry_q;
    data_d  = data_q;
    unique case (state_q)
      MONITOR: begin
        if (sel_found) begin
          state_d = REQ;
          repl_d  = sel_repl;
          entry_d = sel_entry;
          data_d  = result_o[sel_entry];
        end
      end
      REQ: begin
        if (scrub_ack_i) begin
          state_d = SETTLE;
        end
      end
      SETTLE:  state_d = MONITOR;
      default: state_d = MONITOR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MONITOR;
      repl_q  <= '0;
      entry_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      repl_q  <= repl_d;
      entry_q <= entry_d;
      data_q  <= data_d;
    end
  end

  assign scrub_req_o   = (state_q == REQ);
  assign scrub_repl_o  = repl_q;
  assign scrub_entry_o = entry_q;
  assign scrub_data_o  = data_q;
`else
  logic unused_scrub_ack;

  assign unused_scrub_ack = scrub_ack_i;
  assign scrub_req_o      = 1'b0;
  assign scrub_repl_o     = '0;
  assign scrub_entry_o    = '0;
  assign scrub_data_o     = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_voter_scrub_2d.sv
// tb/tb_cv32e40p_voter_scrub_2d.sv - self-checking bench for cv32e40p_voter_scrub_2d
// Scrub payloads are predicted into a queue at stimulus time and popped when req is seen.
module tb_cv32e40p_voter_scrub_2d;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 16;
  localparam int unsigned TH = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned EW = 4;

  typedef struct packed {
    logic [1:0]    repl;
    logic [EW-1:0] entry;
    logic [W-1:0]  data;
  } scrub_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0][W-1:0] res1, res2, res3, result;
  logic [N-1:0]        mismatch;
  logic [CW-1:0]       err_cnt;
  logic [2:0]          faulty;
  logic                unrecov, clear, scrub_req, scrub_ack;
  logic [1:0]          scrub_repl;
  logic [EW-1:0]       scrub_entry;
  logic [W-1:0]        scrub_data;

  scrub_t exp_q[$];
  scrub_t exp_s;
  scrub_t got_s;
  int     n_cmp = 0;
  int     n_err = 0;

  always #5 clk = ~clk;

  assign got_s = {scrub_repl, scrub_entry, scrub_data};

  cv32e40p_voter_scrub_2d #(
    .WIDTH(W), .N_ENTRIES(N), .THRESH(TH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .res1_i(res1), .res2_i(res2), .res3_i(res3),
    .result_o(result), .mismatch_o(mismatch), .err_cnt_o(err_cnt),
    .faulty_o(faulty), .unrecov_o(unrecov), .clear_i(clear),
    .scrub_req_o(scrub_req), .scrub_repl_o(scrub_repl), .scrub_entry_o(scrub_entry),
    .scrub_data_o(scrub_data), .scrub_ack_i(scrub_ack)
  );

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; scrub_ack = 1'b0;
    res1 = '0; res2 = '0; res3 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b expected 0", scrub_req); end
    n_cmp++; if (got_s !== '0) begin n_err++; $display("FAIL reset_payload: got %0h expected 0", got_s); end
    n_cmp++; if (err_cnt !== '0) begin n_err++; $display("FAIL reset_err_cnt: got %0h expected 0", err_cnt); end
    n_cmp++; if (faulty !== 3'b000) begin n_err++; $display("FAIL reset_faulty: got %0b expected 000", faulty); end
    n_cmp++; if (unrecov !== 1'b0) begin n_err++; $display("FAIL reset_unrecov: got %0b expected 0", unrecov); end
  endtask

  task automatic test_all_equal();
    logic [N-1:0][W-1:0] exp_arr;
    for (int e = 0; e < int'(N); e++) exp_arr[e] = 32'hA5A5_A5A5;
    @(negedge clk);
    res1 = exp_arr; res2 = exp_arr; res3 = exp_arr;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (result !== exp_arr) begin n_err++; $display("FAIL equal_result: got %0h expected %0h", result[0], exp_arr[0]); end
      n_cmp++; if (mismatch !== '0) begin n_err++; $display("FAIL equal_mismatch: got %0h expected 0", mismatch); end
      n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL equal_req: got %0b expected 0", scrub_req); end
      @(negedge clk);
    end
    n_cmp++; if (err_cnt !== '0) begin n_err++; $display("FAIL equal_err_cnt: got %0h expected 0", err_cnt); end
  endtask

  task automatic test_single_fault();
    do_reset();
    @(negedge clk);
    res2[3] = 32'h0000_0001;
    #1;
    n_cmp++; if (result[3] !== 32'h0) begin n_err++; $display("FAIL single_result: got %0h expected 0", result[3]); end
    n_cmp++; if (mismatch !== 16'h0008) begin n_err++; $display("FAIL single_mismatch: got %0h expected 0008", mismatch); end
`ifdef CV32E40P_VOTER_SCRUB_EN
    exp_q.push_back({2'd1, 4'd3, 32'h0});
`endif
    @(negedge clk);
`ifdef CV32E40P_VOTER_SCRUB_EN
    n_cmp++; if (scrub_req !== 1'b1) begin n_err++; $display("FAIL single_req: got %0b expected 1", scrub_req); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL single_sb: got empty queue expected entry"); end
    else begin
      exp_s = exp_q.pop_front();
      if (got_s !== exp_s) begin n_err++; $display("FAIL single_payload: got %0h expected %0h", got_s, exp_s); end
    end
`else
    n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL single_req_off: got %0b expected 0", scrub_req); end
    n_cmp++; if (got_s !== '0) begin n_err++; $display("FAIL single_payload_off: got %0h expected 0", got_s); end
`endif
    @(negedge clk);
`ifdef CV32E40P_VOTER_SCRUB_EN
    n_cmp++; if (scrub_req !== 1'b1 || got_s !== exp_s) begin n_err++; $display("FAIL single_hold: got req %0b payload %0h expected 1 %0h", scrub_req, got_s, exp_s); end
`endif
    scrub_ack = 1'b1; res2[3] = '0;
    @(negedge clk);
    scrub_ack = 1'b0;
    n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL single_settle: got %0b expected 0", scrub_req); end
    @(negedge clk);
    n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL single_monitor: got %0b expected 0", scrub_req); end
    n_cmp++; if (err_cnt !== 4'd2) begin n_err++; $display("FAIL single_err_cnt: got %0d expected 2", err_cnt); end
    n_cmp++; if (faulty !== 3'b000) begin n_err++; $display("FAIL single_faulty: got %0b expected 000", faulty); end
    scrub_ack = 1'b1;
    @(negedge clk);
    scrub_ack = 1'b0;
    n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL ack_low_ignored: got %0b expected 0", scrub_req); end
  endtask

  task automatic test_threshold();
    do_reset();
    @(negedge clk);
    res2[3] = 32'h0000_0001;
    for (int k = 1; k <= int'(TH); k++) begin
      @(negedge clk);
      n_cmp++;
      if (faulty !== ((k >= int'(TH)) ? 3'b010 : 3'b000))
        begin n_err++; $display("FAIL thresh_faulty_%0d: got %0b expected %0b", k, faulty, (k >= int'(TH)) ? 3'b010 : 3'b000); end
    end
    n_cmp++; if (unrecov !== 1'b0) begin n_err++; $display("FAIL thresh_unrecov: got %0b expected 0", unrecov); end
  endtask

  task automatic test_glitch();
    do_reset();
    @(negedge clk);
    res2[3] = 32'h0000_0001;
    repeat (2) @(negedge clk);
    res2[3] = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (faulty !== 3'b000) begin n_err++; $display("FAIL glitch_faulty_%0d: got %0b expected 000", k, faulty); end
    end
  endtask

  task automatic test_two_faults();
    do_reset();
    @(negedge clk);
    res1[5] = 32'hFFFF_0000; res3[9] = 32'h0000_FFFF;
    #1;
    n_cmp++; if (mismatch !== 16'h0220) begin n_err++; $display("FAIL two_mismatch: got %0h expected 0220", mismatch); end
    n_cmp++; if (result[5] !== 32'h0 || result[9] !== 32'h0) begin n_err++; $display("FAIL two_result: got %0h %0h expected 0 0", result[5], result[9]); end
`ifdef CV32E40P_VOTER_SCRUB_EN
    exp_q.push_back({2'd0, 4'd5, 32'h0});
`endif
    @(negedge clk);
`ifdef CV32E40P_VOTER_SCRUB_EN
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL two_sb_first: got empty queue expected entry"); end
    else begin
      exp_s = exp_q.pop_front();
      if (scrub_req !== 1'b1 || got_s !== exp_s) begin n_err++; $display("FAIL two_first: got req %0b payload %0h expected 1 %0h", scrub_req, got_s, exp_s); end
    end
`else
    n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL two_req_off: got %0b expected 0", scrub_req); end
`endif
    repeat (2) @(negedge clk);
    n_cmp++; if (faulty !== 3'b000) begin n_err++; $display("FAIL two_faulty_early: got %0b expected 000", faulty); end
    @(negedge clk);
    n_cmp++; if (faulty !== 3'b101) begin n_err++; $display("FAIL two_faulty: got %0b expected 101", faulty); end
    n_cmp++; if (unrecov !== 1'b1) begin n_err++; $display("FAIL two_unrecov: got %0b expected 1", unrecov); end
    scrub_ack = 1'b1; res1[5] = '0;
`ifdef CV32E40P_VOTER_SCRUB_EN
    exp_q.push_back({2'd2, 4'd9, 32'h0});
`endif
    @(negedge clk);
    scrub_ack = 1'b0;
    n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL two_settle: got %0b expected 0", scrub_req); end
    @(negedge clk);
    n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL two_gap: got %0b expected 0", scrub_req); end
    @(negedge clk);
`ifdef CV32E40P_VOTER_SCRUB_EN
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL two_sb_second: got empty queue expected entry"); end
    else begin
      exp_s = exp_q.pop_front();
      if (scrub_req !== 1'b1 || got_s !== exp_s) begin n_err++; $display("FAIL two_second: got req %0b payload %0h expected 1 %0h", scrub_req, got_s, exp_s); end
    end
`else
    n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL two_second_off: got %0b expected 0", scrub_req); end
`endif
    n_cmp++; if (unrecov !== 1'b1) begin n_err++; $display("FAIL two_unrecov_sticky: got %0b expected 1", unrecov); end
  endtask

  task automatic test_clear();
    do_reset();
    @(negedge clk);
    res2[0] = 32'h0000_0100;
`ifdef CV32E40P_VOTER_SCRUB_EN
    exp_q.push_back({2'd1, 4'd0, 32'h0});
`endif
    @(negedge clk);
`ifdef CV32E40P_VOTER_SCRUB_EN
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL clear_sb: got empty queue expected entry"); end
    else begin
      exp_s = exp_q.pop_front();
      if (scrub_req !== 1'b1 || got_s !== exp_s) begin n_err++; $display("FAIL clear_req: got req %0b payload %0h expected 1 %0h", scrub_req, got_s, exp_s); end
    end
`endif
    repeat (3) @(negedge clk);
    n_cmp++; if (faulty !== 3'b010) begin n_err++; $display("FAIL clear_pre_faulty: got %0b expected 010", faulty); end
    n_cmp++; if (err_cnt !== 4'd4) begin n_err++; $display("FAIL clear_pre_err: got %0d expected 4", err_cnt); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_cmp++; if (err_cnt !== '0) begin n_err++; $display("FAIL clear_err: got %0d expected 0", err_cnt); end
    n_cmp++; if (faulty !== 3'b000) begin n_err++; $display("FAIL clear_faulty: got %0b expected 000", faulty); end
`ifdef CV32E40P_VOTER_SCRUB_EN
    n_cmp++; if (scrub_req !== 1'b1) begin n_err++; $display("FAIL clear_req_kept: got %0b expected 1", scrub_req); end
`endif
    @(negedge clk);
    n_cmp++; if (err_cnt !== 4'd1) begin n_err++; $display("FAIL clear_err_resume: got %0d expected 1", err_cnt); end
    scrub_ack = 1'b1; res2[0] = '0;
    @(negedge clk);
    scrub_ack = 1'b0;
    n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL clear_ack: got %0b expected 0", scrub_req); end
  endtask

  task automatic test_err_sat();
    int unsigned exp_cnt;
    do_reset();
    @(negedge clk);
    res3[7] = 32'h0000_0001;
    exp_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (exp_cnt < (2 ** CW) - 1) exp_cnt++;
      n_cmp++; if (err_cnt !== CW'(exp_cnt)) begin n_err++; $display("FAIL err_sat_%0d: got %0d expected %0d", k, err_cnt, exp_cnt); end
    end
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    @(negedge clk);
    res3[15] = 32'h8000_0000;
`ifdef CV32E40P_VOTER_SCRUB_EN
    exp_q.push_back({2'd2, 4'd15, 32'h0});
`endif
    @(negedge clk);
`ifdef CV32E40P_VOTER_SCRUB_EN
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL rst_sb: got empty queue expected entry"); end
    else begin
      exp_s = exp_q.pop_front();
      if (scrub_req !== 1'b1 || got_s !== exp_s) begin n_err++; $display("FAIL rst_pre_req: got req %0b payload %0h expected 1 %0h", scrub_req, got_s, exp_s); end
    end
`else
    n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL rst_req_off: got %0b expected 0", scrub_req); end
`endif
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (scrub_req !== 1'b0) begin n_err++; $display("FAIL rst_async_req: got %0b expected 0", scrub_req); end
    n_cmp++; if (got_s !== '0) begin n_err++; $display("FAIL rst_async_payload: got %0h expected 0", got_s); end
    n_cmp++; if (err_cnt !== '0 || faulty !== 3'b000) begin n_err++; $display("FAIL rst_async_cnt: got %0d %0b expected 0 000", err_cnt, faulty); end
    res3 = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; scrub_ack = 1'b0;
    res1 = '0; res2 = '0; res3 = '0;
    test_reset();
    test_all_equal();
    test_single_fault();
    test_threshold();
    test_glitch();
    test_two_faults();
    test_clear();
    test_err_sat();
    test_reset_mid_req();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d left expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
